fetch_unit: RTL and testbench

- Instruction fetch stage of the RV32I core, directly upstream of decode.
- Its output word feeds the decoder and imm_gen.
- Holds the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Buffers one fetched instruction toward decode with a valid/ready handshake, and handles branch/jump redirects, including discarding in-flight stale responses.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit_buf.sv | 37 +++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch bus bundle (imem, redirect, decode); FETCH_MISALIGN_CHECK_EN adds fetch_misalign
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic              fetch_misalign;
`endif

    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output fetch_misalign,
`endif
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  fetch_misalign,
`endif
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_unit_buf.sv
// rtl/fetch_unit_buf.sv - one-entry valid/ready instruction buffer with clear
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              ready,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    // Clear beats load beats drain; data is only rewritten on load so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= RESET_PC;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, one-outstanding imem FSM, redirect/drop; option FETCH_MISALIGN_CHECK_EN
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_target;
    logic              accept;
    logic              buf_load;

    // A new request only goes out once the buffer is empty or being drained this cycle.
    assign bus.imem_req  = rst_n && (state == S_REQ) && (!bus.instr_valid || bus.instr_ready);
    assign bus.imem_addr = pc;
    assign accept        = bus.imem_req && bus.imem_ready;
    assign buf_load      = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;

    // Redirect target, word-aligned when the misalignment check is built in.
    always_comb begin
        redirect_target = bus.redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_target[1:0] = 2'b00;
`endif
    end

    // Request/response FSM and PC; a redirect wins and decides whether a stale response must be dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= redirect_target;
            case (state)
                S_REQ:   state <= accept ? S_DROP : S_REQ;
                S_WAIT:  state <= bus.imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state <= bus.imem_rvalid ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        pc    <= pc + ADDR_W'(4);
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rvalid) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky flag for the most recent redirect's alignment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.fetch_misalign <= 1'b0;
        end else if (bus.redirect_valid) begin
            bus.fetch_misalign <= |bus.redirect_pc[1:0];
        end
    end
`endif

    fetch_buf #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (bus.redirect_valid),
        .load       (buf_load),
        .load_instr (bus.imem_rdata),
        .load_pc    (pc),
        .ready      (bus.instr_ready),
        .valid      (bus.instr_valid),
        .instr      (bus.instr),
        .pc         (bus.instr_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (optionally with FETCH_MISALIGN_CHECK_EN)
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32)) bus ();

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // snapshot of the cycle just sampled
    logic        s_req, s_mready, s_rvalid, s_redir, s_valid, s_ready, s_mis;
    logic [31:0] s_addr, s_instr, s_ipc, s_rpc;

    // specification-level model
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_ipc   = 32'h0;
    logic [31:0] m_pc    = 32'h0;
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_oaddr = 32'h0;
    logic        m_mis   = 1'b0;
    logic [31:0] consumed[$];

    // memory model
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    logic        mem_busy = 1'b0;
    logic        acc_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h6cdf_f6e7;
        return {a[15:0] ^ 16'h5a5a, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        logic        acc, was_out, was_stale;
        logic [31:0] old_pc;
        s_req = bus.imem_req;       s_addr = bus.imem_addr;  s_mready = bus.imem_ready;
        s_rvalid = bus.imem_rvalid; s_redir = bus.redirect_valid; s_rpc = bus.redirect_pc;
        s_valid = bus.instr_valid;  s_instr = bus.instr;     s_ipc = bus.instr_pc;
        s_ready = bus.instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
        s_mis = bus.fetch_misalign;
        check("misalign", s_mis, m_mis);
`else
        s_mis = 1'b0;
`endif
        check("instr_valid", s_valid, m_valid);
        if (m_valid) begin
            check("instr", s_instr, m_instr);
            check("instr_pc", s_ipc, m_ipc);
        end
        if (!rst_n) begin
            check("req_in_reset", s_req, 1'b0);
            m_valid = 1'b0; m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_mis = 1'b0;
        end else begin
            check("imem_req", s_req, !m_out && (!m_valid || s_ready));
            check("imem_addr", s_addr, m_pc);
            acc       = s_req && s_mready;
            was_out   = m_out;
            was_stale = m_stale;
            old_pc    = m_pc;
            if (s_rvalid) m_out = 1'b0;
            if (s_valid && s_ready) consumed.push_back(s_ipc);
            if (s_redir) begin
                m_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                m_pc  = {s_rpc[31:2], 2'b00};
                m_mis = (s_rpc[1:0] != 2'b00);
`else
                m_pc  = s_rpc;
`endif
            end else begin
                if (m_valid && s_ready) m_valid = 1'b0;
                if (s_rvalid && was_out && !was_stale) begin
                    m_valid = 1'b1;
                    m_instr = mem_word(m_oaddr);
                    m_ipc   = m_oaddr;
                    m_pc    = m_oaddr + 32'd4;
                end
            end
            if (acc) begin
                m_out    = 1'b1;
                m_stale  = 1'b0;
                m_oaddr  = old_pc;
                mem_addr = s_addr;
                acc_pend = 1'b1;
            end
            if (s_redir) m_stale = m_out;
        end
    endtask

    task automatic mem_cycle();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hdead_beef;
        if (!rst_n) begin
            mem_busy = 1'b0;
            acc_pend = 1'b0;
        end else if (acc_pend) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
            end
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mem_addr);
                mem_busy = 1'b0;
                acc_pend = 1'b0;
            end
        end
    endtask

    // inputs set by the caller after step() apply to the next sample and edge
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        mem_cycle();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!s_req && n < 50) begin step(); n++; end
        check(name, s_req, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!s_valid && n < 50) begin step(); n++; end
        check(name, s_valid, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int          idx, hits, n;
        logic [31:0] pc0, w0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b1;

        // reset
        step();
        step();
        check("rst_valid", s_valid, 1'b0);
        check("rst_instr", s_instr, 32'h0000_0013);
        check("rst_pc", s_ipc, 32'h0);
        check("rst_req", s_req, 1'b0);
        rst_n = 1'b1;

        // first fetches
        step();
        wait_req("wait_first_req");
        check("first_addr", s_addr, 32'h0);
        wait_valid("wait_first_instr");
        check("first_instr", s_instr, 32'h6cdf_f6e7);
        check("first_instr_pc", s_ipc, 32'h0);
        wait_req("wait_second_req");
        check("second_addr", s_addr, 32'h4);

        // backpressure, then a memory that is not ready
        bus.instr_ready = 1'b0;
        step();
        wait_valid("wait_bp_valid");
        pc0 = s_ipc;
        w0  = s_instr;
        check("bp_pc", pc0, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", s_valid, 1'b1);
            check("bp_hold_pc", s_ipc, pc0);
            check("bp_hold_instr", s_instr, w0);
            check("bp_no_req", s_req, 1'b0);
        end
        bus.instr_ready = 1'b1;
        bus.imem_ready  = 1'b0;
        step();
        check("bp_release_req", s_req, 1'b1);
        check("bp_release_addr", s_addr, 32'h8);
        step();
        step();
        check("mem_stall_req", s_req, 1'b1);

        // redirect while waiting on 0x8
        mem_lat = 3;
        bus.imem_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(s_req && s_mready && s_addr == 32'h8) && n < 50);
        check("accept_8", s_addr, 32'h8);
        idx = consumed.size();
        redirect(32'h100);
        check("redir_before_rvalid", s_rvalid, 1'b0);
        step();
        wait_req("wait_req_100");
        check("addr_100", s_addr, 32'h100);
        wait_valid("wait_instr_100");
        check("instr_pc_100", s_ipc, 32'h100);
        hits = 0;
        for (int i = idx; i < consumed.size(); i++) if (consumed[i] == 32'h8) hits++;
        check("dropped_8", hits, 0);

        // redirect in the same cycle as rvalid with instr_ready high
        mem_lat = 2;
        n = 0;
        do begin step(); n++; end while (!bus.imem_rvalid && n < 50);
        redirect(32'h200);
        check("coincide_rvalid", s_rvalid, 1'b1);
        check("coincide_ready", s_ready, 1'b1);
        step();
        check("coincide_cleared", s_valid, 1'b0);
        check("coincide_req", s_req, 1'b1);
        check("coincide_addr", s_addr, 32'h200);
        wait_valid("wait_instr_200");
        check("instr_pc_200", s_ipc, 32'h200);

        // PC wrap
        mem_lat = 1;
        redirect(32'hFFFF_FFFC);
        step();
        wait_req("wait_req_top");
        check("addr_top", s_addr, 32'hFFFF_FFFC);
        wait_valid("wait_instr_top");
        check("instr_pc_top", s_ipc, 32'hFFFF_FFFC);
        wait_req("wait_req_wrap");
        check("addr_wrap", s_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect(32'h102);
        step();
        check("misalign_set", s_mis, 1'b1);
        wait_req("wait_req_mis");
        check("misalign_addr", s_addr, 32'h100);
        redirect(32'h200);
        step();
        check("misalign_clear", s_mis, 1'b0);
`endif

        for (int i = 0; i < 10; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
